// File: rtl/piso_tx_ctrl_pkg.sv
// Shared types and helpers for the parallel-to-serial transmit sequencer.
package piso_tx_ctrl_pkg;

   // Sequencer states; SETTLE absorbs the registered output of the shift memory.
   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SETTLE,
      SEND,
      SHIFT,
      DONE
   } state_t;

   // Width of a word index for an n-element vector, never narrower than one bit.
   function automatic int idx_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/piso_tx_ctrl_pisomem.sv
// Parallel-in serial-out word memory: load a whole vector, then shift one
// element per enable toward slot 0. The output is a registered copy of slot 0,
// so it trails the shift registers by one cycle.
module pisoMem #(
   parameter int IWIDTH  = 10,
   parameter int NINPUTS = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        load,
   input  logic                        en,
   input  logic [NINPUTS*IWIDTH-1:0]   in,
   output logic [IWIDTH-1:0]           out
);

   logic [IWIDTH-1:0] shift_regs [NINPUTS];

   // Load the vector, or shift it down by one element, and register slot 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NINPUTS; i++) begin
            shift_regs[i] <= '0;
         end
         out <= '0;
      end else begin
         if (load) begin
            for (int i = 0; i < NINPUTS; i++) begin
               shift_regs[i] <= in[i*IWIDTH +: IWIDTH];
            end
         end else if (en) begin
            for (int i = 0; i < NINPUTS - 1; i++) begin
               shift_regs[i] <= shift_regs[i+1];
            end
            shift_regs[NINPUTS-1] <= '0;
         end
         out <= shift_regs[0];
      end
   end

endmodule

// File: rtl/piso_tx_ctrl.sv
// Drains one parallel result vector, element 0 first, into a single-word
// serial consumer through a tx_start/tx_ready handshake. Owns the load, shift
// and reset strobes of the internal pisoMem.
module piso_tx_ctrl
   import piso_tx_ctrl_pkg::*;
#(
   parameter int IWIDTH  = 10,
   parameter int NINPUTS = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic [NINPUTS*IWIDTH-1:0]      in,
   input  logic                           tx_ready,
   output logic                           tx_start,
   output logic [IWIDTH-1:0]              tx_data,
   output logic                           busy,
   output logic                           done,
   output logic [idx_w(NINPUTS)-1:0]      word_idx
);

   localparam int                IDX_W    = idx_w(NINPUTS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NINPUTS - 1);

   state_t            state;
   state_t            state_next;
   logic [IDX_W-1:0]  word_idx_next;
   logic              mem_load;
   logic              mem_en;
   logic [IWIDTH-1:0] mem_out;

   pisoMem #(
      .IWIDTH  (IWIDTH),
      .NINPUTS (NINPUTS)
   ) u_mem (
      .clk  (clk),
      .rst  (rst),
      .load (mem_load),
      .en   (mem_en),
      .in   (in),
      .out  (mem_out)
   );

   // State and word counter; reset abandons any transfer without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         word_idx <= '0;
      end else begin
         state    <= state_next;
         word_idx <= word_idx_next;
      end
   end

   // Next-state, counter update and output decode from state, word_idx and tx_ready.
   always_comb begin
      state_next    = state;
      word_idx_next = word_idx;
      mem_load      = 1'b0;
      mem_en        = 1'b0;
      tx_start      = 1'b0;
      tx_data       = '0;
      busy          = 1'b1;
      done          = 1'b0;

      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            mem_load      = 1'b1;
            word_idx_next = '0;
            state_next    = SETTLE;
         end
         SETTLE: begin
            // pisoMem out catches up with the new slot 0 here.
            state_next = SEND;
         end
         SEND: begin
            if (tx_ready) begin
               tx_start = 1'b1;
               tx_data  = mem_out;
               if (word_idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  state_next = SHIFT;
               end
            end
         end
         SHIFT: begin
            mem_en        = 1'b1;
            word_idx_next = word_idx + IDX_W'(1);
            state_next    = SETTLE;
         end
         DONE: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: expected words and done cycles are queued
// when a transfer is launched and retired by a monitor as strobes appear.
module tb_piso_tx_ctrl;

   localparam int IW  = 10;
   localparam int NIN = 8;

   typedef struct {
      logic [IW-1:0] data;
      int            cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [NIN*IW-1:0] in;
   logic              tx_ready;
   logic              tx_start;
   logic [IW-1:0]     tx_data;
   logic              busy;
   logic              done;
   logic [2:0]        word_idx;

   logic              start1;
   logic [IW-1:0]     in1;
   logic              tx_start1;
   logic [IW-1:0]     tx_data1;
   logic              busy1;
   logic              done1;
   logic [0:0]        word_idx1;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   base;
   bit   mon_en = 1'b0;
   exp_t exp_q[$];
   int   done_q[$];

   piso_tx_ctrl #(.IWIDTH(IW), .NINPUTS(NIN)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .in       (in),
      .tx_ready (tx_ready),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .busy     (busy),
      .done     (done),
      .word_idx (word_idx)
   );

   piso_tx_ctrl #(.IWIDTH(IW), .NINPUTS(1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .start    (start1),
      .in       (in1),
      .tx_ready (1'b1),
      .tx_start (tx_start1),
      .tx_data  (tx_data1),
      .busy     (busy1),
      .done     (done1),
      .word_idx (word_idx1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NIN*IW-1:0] mkvec(input int first, input int dir);
      logic [NIN*IW-1:0] v;
      for (int i = 0; i < NIN; i++) begin
         v[i*IW +: IW] = IW'(first + dir * i);
      end
      return v;
   endfunction

   task automatic push_word(input int data, input int c);
      exp_t e;
      e.data = IW'(data);
      e.cyc  = c;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: retire one expectation per strobe and per done pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         if (tx_start === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_strobe: observed data %0h at cycle %0d expected no strobe", tx_data, cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checks++;
               assert (tx_data === e.data) else begin
                  errors++;
                  $error("FAIL strobe_data: observed %0h expected %0h", tx_data, e.data);
               end
               checks++;
               assert (cyc === e.cyc) else begin
                  errors++;
                  $error("FAIL strobe_cycle: observed %0d expected %0d", cyc, e.cyc);
               end
            end
         end else begin
            checks++;
            assert (tx_data === '0) else begin
               errors++;
               $error("FAIL idle_data: observed %0h expected 0", tx_data);
            end
         end
         if (done === 1'b1) begin
            if (done_q.size() == 0) begin
               checks++;
               errors++;
               $error("FAIL unexpected_done: observed done at cycle %0d expected none", cyc);
            end else begin
               int d;
               d = done_q.pop_front();
               checks++;
               assert (cyc === d) else begin
                  errors++;
                  $error("FAIL done_cycle: observed %0d expected %0d", cyc, d);
               end
            end
         end
      end
   end

   initial begin
      rst      = 1'b1;
      start    = 1'b1;
      in       = '0;
      tx_ready = 1'b1;
      start1   = 1'b0;
      in1      = '0;

      // Reset with start held high: everything stays quiet.
      for (int n = 0; n < 3; n++) begin
         step();
         @(negedge clk);
         chk("rst_tx_start", 32'(tx_start), 0);
         chk("rst_tx_data", 32'(tx_data), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_word_idx", 32'(word_idx), 0);
      end
      step();
      rst    = 1'b0;
      start  = 1'b0;
      mon_en = 1'b1;
      step();
      step();
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);

      // Nominal transfer with start pulses while busy.
      step();
      base  = cyc;
      start = 1'b1;
      in    = mkvec(1, 1);
      for (int k = 0; k < NIN; k++) push_word(k + 1, base + 3 + 3 * k);
      done_q.push_back(base + 25);
      for (int n = 1; n <= 26; n++) begin
         step();
         start = (n == 5 || n == 12 || n == 25);
         if (n == 1) begin
            @(negedge clk);
            chk("nom_busy_load", 32'(busy), 1);
         end
         if (n == 9) begin
            @(negedge clk);
            chk("nom_word_idx2", 32'(word_idx), 2);
         end
         if (n == 26) begin
            @(negedge clk);
            chk("nom_busy_after", 32'(busy), 0);
         end
      end
      step();
      start = 1'b0;
      step();

      // Backpressure: tx_ready low for five cycles while word 2 waits.
      base  = cyc;
      start = 1'b1;
      in    = mkvec(16'h101, 1);
      for (int k = 0; k < NIN; k++) push_word(16'h101 + k, base + 3 + 3 * k + ((k >= 2) ? 5 : 0));
      done_q.push_back(base + 30);
      for (int n = 1; n <= 31; n++) begin
         step();
         start    = 1'b0;
         tx_ready = !(n >= 9 && n <= 13);
         if (n == 11) begin
            @(negedge clk);
            chk("bp_hold_busy", 32'(busy), 1);
            chk("bp_hold_idx", 32'(word_idx), 2);
         end
      end
      tx_ready = 1'b1;
      step();

      // Reset in the cycle after word 3 is issued.
      base  = cyc;
      start = 1'b1;
      in    = mkvec(16'h010, 1);
      for (int k = 0; k < 4; k++) push_word(16'h010 + k, base + 3 + 3 * k);
      for (int n = 1; n <= 14; n++) begin
         step();
         start = 1'b0;
         rst   = (n == 13);
         if (n == 14) begin
            @(negedge clk);
            chk("mid_rst_busy", 32'(busy), 0);
            chk("mid_rst_idx", 32'(word_idx), 0);
            chk("mid_rst_done", 32'(done), 0);
         end
      end
      rst = 1'b0;
      step();
      base  = cyc;
      start = 1'b1;
      in    = mkvec(16'h3FF, -1);
      for (int k = 0; k < NIN; k++) push_word(16'h3FF - k, base + 3 + 3 * k);
      done_q.push_back(base + 25);
      for (int n = 1; n <= 26; n++) begin
         step();
         start = 1'b0;
      end
      step();

      // Back-to-back vectors, second start in the cycle after done.
      base  = cyc;
      start = 1'b1;
      in    = mkvec(16'h020, 1);
      for (int k = 0; k < NIN; k++) push_word(16'h020 + k, base + 3 + 3 * k);
      done_q.push_back(base + 25);
      for (int k = 0; k < NIN; k++) push_word(16'h040 + k, base + 29 + 3 * k);
      done_q.push_back(base + 51);
      for (int n = 1; n <= 52; n++) begin
         step();
         start = (n == 26);
         if (n >= 26) in = mkvec(16'h040, 1);
         if (n == 52) begin
            @(negedge clk);
            chk("b2b_busy_after", 32'(busy), 0);
         end
      end
      step();

      // Single-element vector: SHIFT is never visited.
      base   = cyc;
      start1 = 1'b1;
      in1    = 10'h155;
      for (int n = 1; n <= 5; n++) begin
         step();
         start1 = 1'b0;
         @(negedge clk);
         chk("one_tx_start", 32'(tx_start1), (n == 3) ? 1 : 0);
         chk("one_tx_data", 32'(tx_data1), (n == 3) ? 32'h155 : 0);
         chk("one_done", 32'(done1), (n == 4) ? 1 : 0);
         chk("one_busy", 32'(busy1), (n <= 4) ? 1 : 0);
         chk("one_en", 32'(dut1.mem_en), 0);
      end

      step();
      step();
      chk("words_outstanding", 32'(exp_q.size()), 0);
      chk("done_outstanding", 32'(done_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
